// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN inference scheduler.
// States, class encodings and the vote fill-count width.
package snn_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } sched_state_t;

  localparam logic CLASS_STRAIGHT = 1'b0;
  localparam logic CLASS_TURNING  = 1'b1;

  localparam int FILL_W = 4;

endpackage

// File: rtl/snn_desc_fifo.sv
// Frame descriptor queue: registered storage, full/empty flags.
// A word written this cycle is not visible on data_o until the next.
module snn_desc_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/snn_infer_scheduler.sv
// Runs the LIF FC readout core once per queued frame and majority-filters classes.
// Optional per-run watchdog: define SNN_SCHED_TIMEOUT_EN.
module snn_infer_scheduler
  import snn_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int VOTE_WIN       = 5,
  parameter int SEQ_W          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  output logic              core_start,
  output logic [ADDR_W-1:0] core_base,
  input  logic              core_done,
  input  logic              core_class,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_raw,
  output logic              res_filt,
  output logic [SEQ_W-1:0]  res_seq,
  output logic              res_tmo,
  output logic              busy
);

  sched_state_t state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                dprev_q, dprev_d;
  logic                raw_q, raw_d;
  logic                filt_q, filt_d;
  logic [VOTE_WIN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [FILL_W-1:0]   ones;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]   fifo_data;

  snn_desc_fifo #(
    .W     (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid),
    .data_i  (req_base),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SNN_SCHED_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign res_tmo = tmo_q;
`else
  assign res_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      dprev_q <= 1'b0;
      raw_q   <= CLASS_STRAIGHT;
      filt_q  <= CLASS_STRAIGHT;
      hist_q  <= '0;
      fill_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dprev_q <= dprev_d;
      raw_q   <= raw_d;
      filt_q  <= filt_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    dprev_d    = dprev_q;
    raw_d      = raw_q;
    filt_d     = filt_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    seq_d      = seq_q;
    ones       = '0;
    fifo_pop   = 1'b0;
    core_start = 1'b0;
`ifdef SNN_SCHED_TIMEOUT_EN
    wdog_d     = wdog_q;
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          base_d   = fifo_data;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        dprev_d    = core_done;
        state_d    = S_WAIT;
`ifdef SNN_SCHED_TIMEOUT_EN
        wdog_d     = '0;
        tmo_d      = 1'b0;
`endif
      end
      S_WAIT: begin
        dprev_d = core_done;
        if (core_done && !dprev_q) begin
          raw_d     = core_class;
          hist_d[0] = core_class;
          for (int i = 1; i < VOTE_WIN; i++) hist_d[i] = hist_q[i-1];
          if (fill_q != FILL_W'(VOTE_WIN)) fill_d = fill_q + 1'b1;
          for (int i = 0; i < VOTE_WIN; i++) ones = ones + FILL_W'(hist_d[i]);
          // even fill with an exact tie keeps the previous decision
          if ({ones, 1'b0} > {1'b0, fill_d})      filt_d = CLASS_TURNING;
          else if ({ones, 1'b0} < {1'b0, fill_d}) filt_d = CLASS_STRAIGHT;
          state_d = S_RESULT;
`ifdef SNN_SCHED_TIMEOUT_EN
        end else if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          raw_d   = filt_q;
          state_d = S_RESULT;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          seq_d   = seq_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = ~fifo_full;
  assign core_base = base_q;
  assign res_valid = (state_q == S_RESULT);
  assign res_raw   = raw_q;
  assign res_filt  = filt_q;
  assign res_seq   = seq_q;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_snn_infer_scheduler.sv
// Directed bench for snn_infer_scheduler with a core responder and result scoreboard.
// Timeout scenario compiled only with SNN_SCHED_TIMEOUT_EN.
module tb_snn_infer_scheduler;

  localparam int VW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_base = '0;
  logic        core_start;
  logic [15:0] core_base;
  logic        core_done = 1'b0;
  logic        core_class = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_raw;
  logic        res_filt;
  logic [7:0]  res_seq;
  logic        res_tmo;
  logic        busy;

  always #5 clk = ~clk;

  snn_infer_scheduler #(
    .ADDR_W         (16),
    .FIFO_DEPTH     (4),
    .VOTE_WIN       (VW),
    .SEQ_W          (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .core_start (core_start),
    .core_base  (core_base),
    .core_done  (core_done),
    .core_class (core_class),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_raw    (res_raw),
    .res_filt   (res_filt),
    .res_seq    (res_seq),
    .res_tmo    (res_tmo),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] base;
    logic        raw;
    logic        filt;
    logic [7:0]  seq;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] base_q[$];
  logic        cls_q[$];
  logic        filt_log[$];
  bit          hist_m[$];
  logic        filt_m = 1'b0;
  logic [7:0]  seq_m = '0;

  int passed = 0, failed = 0, total = 0;
  int start_cnt = 0, res_cnt = 0;
  int lat = 2;
  bit hold_mode = 0;
  bit never_done = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_frame(logic [15:0] b, logic c, bit tmo);
    exp_t e;
    int   ones;
    e.base = b;
    e.seq  = seq_m;
    e.tmo  = tmo;
    seq_m  = seq_m + 8'd1;
    if (tmo) begin
      e.raw  = filt_m;
      e.filt = filt_m;
    end else begin
      hist_m.push_back(c);
      if (hist_m.size() > VW) void'(hist_m.pop_front());
      ones = 0;
      foreach (hist_m[i]) ones += int'(hist_m[i]);
      if (2 * ones > hist_m.size()) filt_m = 1'b1;
      else if (2 * ones < hist_m.size()) filt_m = 1'b0;
      e.raw  = c;
      e.filt = filt_m;
    end
    exp_q.push_back(e);
  endfunction

  task automatic push(logic [15:0] b, logic c, bit tmo = 0);
    int n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", req_ready, 1);
    req_valid = 1'b1;
    req_base  = b;
    base_q.push_back(b);
    cls_q.push_back(c);
    model_frame(b, c, tmo);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", busy, 0);
    check("idle_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b1;
    exp_q.delete();
    base_q.delete();
    cls_q.delete();
    hist_m.delete();
    filt_m = 1'b0;
    seq_m  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // core model: done is a level that stays high until the next start
  initial begin
    logic c;
    forever begin
      @(negedge clk);
      #1;
      if (core_start) begin
        c = (cls_q.size() != 0) ? cls_q.pop_front() : 1'b0;
        if (hold_mode) begin
          for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            if (k == 4) core_done = 1'b0;
            if (k == 10) begin
              core_class = c;
              core_done  = 1'b1;
            end
          end
        end else if (never_done) begin
          core_done = 1'b0;
        end else begin
          core_done = 1'b0;
          repeat (lat) @(negedge clk);
          #1;
          core_class = c;
          core_done  = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (core_start) begin
        start_cnt++;
        check("issue_pending", base_q.size() != 0, 1);
        if (base_q.size() != 0) check("core_base", core_base, base_q.pop_front());
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (res_valid && res_ready) begin
        res_cnt++;
        check("res_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_raw", res_raw, e.raw);
          check("res_filt", res_filt, e.filt);
          check("res_seq", res_seq, e.seq);
          check("res_tmo", res_tmo, e.tmo);
          check("res_base", core_base, e.base);
          filt_log.push_back(res_filt);
        end
      end
    end
  end

  initial begin
    logic t3_cls[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic t3_filt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t e;
    int   n, c, s0, sc;

    do_reset();
    check("rst_req_ready", req_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_busy", busy, 0);
    check("rst_res_seq", res_seq, 0);
    check("rst_core_base", core_base, 0);
    check("rst_res_filt", res_filt, 0);
    check("rst_res_tmo", res_tmo, 0);

    lat = 20;
    push(16'h0000, 1'b1);
    wait_idle();
    check("t1_starts", start_cnt, 1);
    check("t1_results", res_cnt, 1);

    do_reset();
    lat = 3;
    filt_log.delete();
    for (int i = 0; i < 5; i++) push(16'(32'h100 + i), t3_cls[i]);
    wait_idle();
    check("t3_count", filt_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < filt_log.size()) check("t3_filt", filt_log[i], t3_filt[i]);

    lat = 20;
    s0 = start_cnt;
    for (int i = 0; i < 6; i++) begin
      push(16'(32'h2000 + i * 16), i[0]);
      if (i == 4) begin
        check("t2_full_ready", req_ready, 0);
        check("t2_busy", busy, 1);
      end
    end
    wait_idle();
    check("t2_starts", start_cnt - s0, 6);

    hold_mode = 1;
    s0 = res_cnt;
    push(16'h4444, 1'b1);
    n = 0;
    while (!core_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_start", core_start, 1);
    c = 0;
    while (!res_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t4_latency", c, 11);
    wait_idle();
    hold_mode = 0;
    check("t4_one_result", res_cnt - s0, 1);

    do_reset();
    lat = 1;
    for (int i = 0; i < 256; i++) push(16'(i), 1'($urandom_range(0, 1)));
    wait_idle();
    check("wrap_seq", res_seq, 0);

    res_ready = 1'b0;
    push(16'hA5A5, 1'b1);
    push(16'h5A5A, 1'b0);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_valid", res_valid, 1);
    e  = exp_q[0];
    sc = start_cnt;
    check("t5_seq_wrapped", res_seq, 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("t5_hold_valid", res_valid, 1);
      check("t5_hold_raw", res_raw, e.raw);
      check("t5_hold_filt", res_filt, e.filt);
      check("t5_hold_seq", res_seq, e.seq);
      check("t5_hold_base", core_base, e.base);
    end
    check("t5_no_start", start_cnt, sc);
    res_ready = 1'b1;
    wait_idle();

`ifdef SNN_SCHED_TIMEOUT_EN
    never_done = 1;
    push(16'h6666, 1'b0, 1);
    n = 0;
    while (!core_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_start", core_start, 1);
    c = 0;
    while (!res_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("t6_latency", c, 51);
    check("t6_tmo", res_tmo, 1);
    wait_idle();
    never_done = 0;
    push(16'h7777, 1'b1);
    wait_idle();
`endif

    check("end_exp_empty", exp_q.size(), 0);
    check("end_base_empty", base_q.size(), 0);
    check("end_cls_empty", cls_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
